mul_ctrl: RTL

- Execute-stage controller sitting directly upstream of the multiplier core (the `mul` block: trig/okay handshake, 2*XLEN product).
- Accepts RV M-extension multiply ops from the EX pipeline, prepares operands and signedness, and pulses the core's trigger.
- Waits for the core's okay, then selects the low or high half (RV64 W-ops: low 32 bits, sign-extended) and returns rd_data with a stall/valid handshake to the pipeline.

---
 rtl/mul_pkg.sv | 44 ++++
 rtl/mul_reuse_tag.sv | 61 ++++++
 rtl/mul_ctrl.sv | 130 +++++++++++++
 3 files changed

// File: rtl/mul_pkg.sv
// Shared types for the multiply controller: op and state encodings plus the
// op-to-signedness lookup. `XLEN defaults to 64 when the build does not set it.
`ifndef XLEN
`define XLEN 64
`endif

package mul_pkg;

  typedef enum logic [1:0] {
    MUL    = 2'd0,
    MULH   = 2'd1,
    MULHSU = 2'd2,
    MULHU  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DONE  = 2'd2,
    DRAIN = 2'd3
  } state_e;

  typedef struct packed {
    logic s1;
    logic s2;
  } sign_t;

  // W-ops always multiply sign-extended 32-bit operands as signed.
  function automatic sign_t op_sign(input op_e op, input logic word);
    sign_t s;
    s = '{s1: 1'b0, s2: 1'b0};
    if (word) begin
      s = '{s1: 1'b1, s2: 1'b1};
    end else begin
      case (op)
        MULH:    s = '{s1: 1'b1, s2: 1'b1};
        MULHSU:  s = '{s1: 1'b1, s2: 1'b0};
        default: s = '{s1: 1'b0, s2: 1'b0};
      endcase
    end
    return s;
  endfunction

endpackage

// File: rtl/mul_reuse_tag.sv
// Last-product cache for the multiply controller (used only when MULDIV_REUSE_EN
// is defined): operand/signedness tag, stored full product and hit compare.
module mul_reuse_tag
  import mul_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              capture,
  input  logic              commit,
  input  logic              inval,
  input  logic [XLEN-1:0]   src1,
  input  logic [XLEN-1:0]   src2,
  input  logic              word,
  input  logic              signed1,
  input  logic              signed2,
  input  logic              op_is_mul,
  input  logic [2*XLEN-1:0] prod_in,
  output logic              hit,
  output logic [2*XLEN-1:0] prod
);

  logic [XLEN-1:0]   src1_reg;
  logic [XLEN-1:0]   src2_reg;
  logic              word_reg;
  logic [1:0]        sgn_reg;
  logic              valid_reg;
  logic [2*XLEN-1:0] prod_reg;

  // Key is taken at trigger time; the entry only becomes valid once the
  // matching product arrives, so a stale product is never paired with a new key.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      src1_reg  <= '0;
      src2_reg  <= '0;
      word_reg  <= 1'b0;
      sgn_reg   <= 2'b00;
      valid_reg <= 1'b0;
      prod_reg  <= '0;
    end else if (inval) begin
      valid_reg <= 1'b0;
    end else if (capture) begin
      src1_reg  <= src1;
      src2_reg  <= src2;
      word_reg  <= word;
      sgn_reg   <= {signed1, signed2};
      valid_reg <= 1'b0;
    end else if (commit) begin
      valid_reg <= 1'b1;
      prod_reg  <= prod_in;
    end
  end

  // The low half does not depend on signedness, so MUL may reuse any entry.
  assign hit  = valid_reg && (src1_reg == src1) && (src2_reg == src2) &&
                (word_reg == word) &&
                ((sgn_reg == {signed1, signed2}) || op_is_mul);
  assign prod = prod_reg;

endmodule

// File: rtl/mul_ctrl.sv
// EX-stage controller in front of the multiplier core: operand/signedness prep,
// trig/okay handshake, result half select. MULDIV_REUSE_EN adds product reuse.
module mul_ctrl
  import mul_pkg::*;
#(
  parameter int XLEN = `XLEN
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req,
  input  logic              flush,
  input  logic [1:0]        op,
  input  logic              word,
  input  logic [XLEN-1:0]   src1,
  input  logic [XLEN-1:0]   src2,
  output logic              stall,
  output logic              rd_valid,
  output logic [XLEN-1:0]   rd_data,
  output logic              mul_trig,
  output logic              mul_signed1,
  output logic              mul_signed2,
  output logic [XLEN-1:0]   mul_src1,
  output logic [XLEN-1:0]   mul_src2,
  input  logic [2*XLEN-1:0] mul_out,
  input  logic              mul_okay
);

  state_e          state_reg, state_next;
  op_e             op_in, op_reg;
  logic            word_in, word_reg;
  sign_t           sgn;
  logic            accept;
  logic            hit;
  logic [XLEN-1:0] rd_data_reg, rd_data_next;

  function automatic logic [XLEN-1:0] sel_result(input logic [2*XLEN-1:0] prod,
                                                 input op_e o, input logic w);
    if (w)
      return XLEN'(signed'(prod[31:0]));
    else if (o == MUL)
      return prod[XLEN-1:0];
    else
      return prod[2*XLEN-1:XLEN];
  endfunction

  assign op_in   = op_e'(op);
  assign word_in = (XLEN == 64) && word;
  assign sgn     = op_sign(op_in, word_in);

  assign mul_signed1 = sgn.s1;
  assign mul_signed2 = sgn.s2;
  assign mul_src1    = word_in ? XLEN'(signed'(src1[31:0])) : src1;
  assign mul_src2    = word_in ? XLEN'(signed'(src2[31:0])) : src2;

  assign accept = (state_reg == IDLE) && req && !flush;

`ifdef MULDIV_REUSE_EN
  logic [2*XLEN-1:0] tag_prod;

  mul_reuse_tag #(.XLEN(XLEN)) u_tag (
    .clk       (clk),
    .rstn      (rstn),
    .capture   (mul_trig),
    .commit    ((state_reg == WAIT) && mul_okay && !flush),
    .inval     (flush || (state_reg == DRAIN)),
    .src1      (src1),
    .src2      (src2),
    .word      (word_in),
    .signed1   (sgn.s1),
    .signed2   (sgn.s2),
    .op_is_mul (op_in == MUL),
    .prod_in   (mul_out),
    .hit       (hit),
    .prod      (tag_prod)
  );
`else
  assign hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (accept) state_next = hit ? DONE : WAIT;
      // A flush racing the core's okay has nothing left to drain.
      WAIT:  if (flush)         state_next = mul_okay ? IDLE : DRAIN;
             else if (mul_okay) state_next = DONE;
      DONE:  state_next = IDLE;
      DRAIN: if (mul_okay) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    mul_trig = accept && !hit;
    stall    = req && (state_reg != DONE);
    rd_valid = (state_reg == DONE) && !flush;
  end

  always_comb begin
    rd_data_next = rd_data_reg;
    if ((state_reg == WAIT) && mul_okay && !flush)
      rd_data_next = sel_result(mul_out, op_reg, word_reg);
`ifdef MULDIV_REUSE_EN
    else if (accept && hit)
      rd_data_next = sel_result(tag_prod, op_in, word_in);
`endif
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      op_reg      <= MUL;
      word_reg    <= 1'b0;
      rd_data_reg <= '0;
    end else begin
      if (accept) begin
        op_reg   <= op_in;
        word_reg <= word_in;
      end
      rd_data_reg <= rd_data_next;
    end
  end

  assign rd_data = rd_data_reg;

endmodule
